// File: rtl/cpu_pkg.sv
// Shared encodings and types for the fetch/branch unit.
package cpu_pkg;

  // Top byte of CBZ and B.cond encodings
  localparam logic [7:0] CBZ_PFX   = 8'b10110100;
  localparam logic [7:0] BCOND_PFX = 8'b01010100;

  // Condition code for "less than" in B.cond
  localparam logic [4:0] COND_LT   = 5'b01011;

  // Registered condition flags, packed as {N,Z,V,C}
  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/branch_target_gen.sv
// Combinational next-address candidates: sequential, unconditional and
// conditional branch targets, all relative to the current PC.
module branch_target_gen #(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] cond_target
);

  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] cond_off;

  // Opcode bits are decoded by the parent; they play no part in targets
  logic unused_opcode_bits;
  assign unused_opcode_bits = &{1'b0, instr[31:26]};

  // Sign-extend the immediates and scale them from words to bytes
  assign br_off   = {{(ADDR_W-28){instr[25]}}, instr[25:0], 2'b00};
  assign cond_off = {{(ADDR_W-21){instr[23]}}, instr[23:5], 2'b00};

  // Modulo-2^ADDR_W adds; wrap-around is intentionally silent
  assign pc_plus4    = pc + ADDR_W'(4);
  assign br_target   = pc + br_off;
  assign cond_target = pc + cond_off;

endmodule

// File: rtl/fetch_branch_unit.sv
// Program counter, condition flags and branch resolution feeding the
// control unit. "B 0" (a branch to itself) is treated as program halt.
module fetch_branch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [31:0]       instr,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [10:0]       opcode,
  input  logic              UBranch,
  input  logic              Branch,
  input  logic              alu_zero,
  input  logic              alu_neg,
  input  logic              alu_ovf,
  input  logic              alu_carry,
  input  logic              flag_we,
  output logic [3:0]        flags,
  output logic              halted
);

  logic [ADDR_W-1:0] pc_reg;
  flags_t            flags_reg;
  fetch_state_t      state_reg;
  logic              halted_reg;

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] cond_target;
  logic [ADDR_W-1:0] pc_next;

  logic is_cbz;
  logic is_blt;
  logic taken_u;
  logic taken_c;
  logic halt_req;

  branch_target_gen #(
    .ADDR_W (ADDR_W)
  ) u_targets (
    .pc          (pc_reg),
    .instr       (instr),
    .pc_plus4    (pc_plus4),
    .br_target   (br_target),
    .cond_target (cond_target)
  );

  assign imem_addr = pc_reg;
  assign opcode    = instr[31:21];
  assign flags     = flags_reg;
  assign halted    = halted_reg;

  // Branch decision uses the flags registered by an earlier instruction,
  // so an instruction can never test flags it is setting itself
  assign is_cbz   = (instr[31:24] == CBZ_PFX);
  assign is_blt   = (instr[31:24] == BCOND_PFX) && (instr[4:0] == COND_LT);
  assign taken_u  = UBranch;
  assign taken_c  = Branch && ((is_cbz && alu_zero) ||
                               (is_blt && (flags_reg.n != flags_reg.v)));
  assign halt_req = UBranch && (instr[25:0] == 26'd0);

  // Next-PC select; the unconditional branch wins over the conditional one
  always_comb begin
    pc_next = pc_plus4;
    if (taken_u) begin
      pc_next = br_target;
    end else if (taken_c) begin
      pc_next = cond_target;
    end
  end

  // Run/halt state machine owning PC, flags and the halted output.
  // Stall is checked before any branch input so X from the control unit
  // cannot reach state while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg     <= RESET_PC;
      flags_reg  <= '0;
      state_reg  <= RUN;
      halted_reg <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (!stall) begin
            if (halt_req) begin
              state_reg  <= HALT;
              halted_reg <= 1'b1;
            end else begin
              pc_reg <= pc_next;
              if (flag_we) begin
                flags_reg <= '{n: alu_neg, z: alu_zero, v: alu_ovf, c: alu_carry};
              end
            end
          end
        end
        HALT: begin
          halted_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_branch_unit.md
Name: fetch_branch_unit

Overview:
- Upstream neighbour of the single-cycle datapath's control unit.
- Owns the program counter and the registered condition flags (N, Z, V, C).
- Drives the instruction address and forwards the 11-bit opcode field to the control unit.
- Consumes the control unit's UBranch/Branch outputs, plus ALU status, to compute the next PC for B, CBZ and B.LT, and detects the "B 0" self-loop as program halt.

Parameters:
- ADDR_W, 64, width of PC and instruction address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC, flags and state this cycle.
- instr  in  32  instruction word read from instruction memory at imem_addr (asynchronous read, same cycle).
- imem_addr  out  ADDR_W  current PC.
- opcode  out  11  instr[31:21], to control unit.
- UBranch  in  1  unconditional-branch control from control unit.
- Branch  in  1  conditional-branch control from control unit.
- alu_zero  in  1  ALU zero result of the current instruction (used for CBZ).
- alu_neg, alu_ovf, alu_carry  in  1 each  ALU status of the current instruction.
- flag_we  in  1  current instruction sets flags (ADDS/SUBS).
- flags  out  4  registered {N,Z,V,C}.
- halted  out  1  high in HALT state.

Behaviour:
- Reset (synchronous; has priority over stall and every other input):
  - PC <= RESET_PC.
  - flags <= 4'b0000.
  - state <= RUN.
  - halted = 0.
- Outputs:
  - imem_addr = PC, combinational from the register.
  - opcode = instr[31:21], combinational.
- Offsets (sign-extended, word-scaled):
  - br_off = sext(instr[25:0]) << 2.
  - cond_off = sext(instr[23:5]) << 2.
  - All adds are modulo 2^ADDR_W; wrap-around is silent.
- Branch decision (combinational, current cycle):
  - is_cbz = (instr[31:24] == 8'b10110100).
  - is_blt = (instr[31:24] == 8'b01010100) && (instr[4:0] == 5'b01011).
  - taken_u = UBranch.
  - taken_c = Branch && ((is_cbz && alu_zero) || (is_blt && (flags.N != flags.V))).
  - Branch high with neither is_cbz nor is_blt: not taken.
- next_pc:
  - taken_u -> PC + br_off.
  - else taken_c -> PC + cond_off.
  - else PC + 4.
  - UBranch has priority if both are asserted.
- Flag rule: B.LT evaluates the registered flags, i.e. the flags written by an earlier instruction. The same instruction cannot both set and test flags.
- State machine, two states, RUN and HALT:
  - RUN, stall=0, UBranch=1 and instr[25:0]==0 -> HALT. PC stays unchanged.
  - RUN, stall=0, otherwise -> PC <= next_pc; if flag_we, flags <= {alu_neg, alu_zero, alu_ovf, alu_carry}.
  - RUN, stall=1 -> PC, flags and state hold; flag_we is ignored.
  - HALT -> PC and flags frozen; flag_we, stall and branch inputs ignored; halted=1. Only reset leaves HALT.
- Latency: new PC is visible one cycle after the fetched instruction. No bubbles, no delay slot.
- Unknowns: X on UBranch/Branch (control unit default case) must not corrupt state when stall=1. With stall=0 the result is undefined and flagged by the bench as an error.

Decomposition:
- Package cpu_pkg holds:
  - opcode-prefix constants (CBZ_PFX 8'b10110100, BCOND_PFX 8'b01010100).
  - COND_LT 5'b01011.
  - typedef flags_t packed struct {N,Z,V,C}.
  - typedef enum fetch_state_t {RUN, HALT}.
- One sub-module: branch_target_gen, a combinational block. Inputs are PC and instr; outputs are pc_plus4, br_target and cond_target.

Test Plan:
- Reset then 3 sequential ADDI fetches, no branches -> imem_addr 0, 4, 8, 12; flags 0; halted 0.
- PC=8, instr=B with imm26=3 (0x14000003), UBranch=1 -> next imem_addr=20; B imm26=-2 at PC=20 -> 12.
- CBZ at PC=16, imm19=4: alu_zero=1 -> 32; alu_zero=0 -> 20.
- SUBS with flag_we=1, neg=1, ovf=0 -> flags=4'b1000. Next cycle B.LT imm19=-1 at PC=40 -> 36. Repeat with neg=1, ovf=1 -> 44.
- stall=1 for 3 cycles with flag_we=1 -> PC and flags unchanged; on release, normal advance.
- B 0 (0x14000000) at PC=24 -> halted=1, imem_addr stays 24 for 5 cycles despite flag_we/stall toggling. reset=1 -> imem_addr=0, halted=0 on the next edge.
